channel_reduce_unit: RTL and testbench

- Fixed-length stream reducer.
- Pops COUNT words from an input channel and sums them with wrap-around.
- Pushes the sum to an output channel once, then raises a sticky done/valid flag.
- Sits between two FIFO-style channel blocks as a leaf compute kernel; it is the hand-written equivalent of the generated 4-element reduce kernel.

---
 rtl/channel_reduce_pkg.sv | 19 +
 rtl/channel_reduce_unit_add.sv | 14 +
 rtl/channel_reduce_unit.sv | 105 ++++++++++
 tb/tb_channel_reduce_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_reduce_pkg.sv
// Shared types and default sizing for the channel reduce kernel.
package channel_reduce_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_COUNT = 4;

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_SETUP    = 4'd1,
    S_WAIT_IN  = 4'd2,
    S_POP      = 4'd3,
    S_ACC      = 4'd4,
    S_CHECK    = 4'd5,
    S_WAIT_OUT = 4'd6,
    S_PUSH     = 4'd7,
    S_DONE     = 4'd8
  } state_t;

endpackage

// File: rtl/channel_reduce_unit_add.sv
// Combinational adder used as the accumulator datapath of the reduce kernel.
module channel_reduce_unit_add
  import channel_reduce_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = in0 + in1;

endmodule

// File: rtl/channel_reduce_unit.sv
// Fixed-length stream reducer: pops COUNT words, pushes their sum once, then holds valid.
// Build option: CHANNEL_REDUCE_SATURATE_EN selects an unsigned saturating accumulator.
module channel_reduce_unit
  import channel_reduce_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int COUNT = DEFAULT_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_out_data,
  input  logic             in_read_ready,
  output logic             in_read_valid,
  output logic [WIDTH-1:0] in_in_data,
  output logic             in_write_valid,
  output logic             in_rst,
  output logic [WIDTH-1:0] out_in_data,
  input  logic             out_write_ready,
  output logic             out_write_valid,
  output logic             out_read_valid,
  output logic             out_rst,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  output logic             valid
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum_full;
  logic             unused_ok;

  // The extra top bit of the adder is the carry-out for the saturating build.
  function automatic logic [WIDTH-1:0] acc_limit(input logic [WIDTH:0] sum);
`ifdef CHANNEL_REDUCE_SATURATE_EN
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    return WIDTH'(sum);
`endif
  endfunction

  channel_reduce_unit_add #(
    .WIDTH(WIDTH + 1)
  ) u_add (
    .in0({1'b0, acc_q}),
    .in1({1'b0, in_out_data}),
    .out(sum_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == S_ACC) begin
        acc_q <= acc_limit(sum_full);
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    in_read_valid   = 1'b0;
    out_write_valid = 1'b0;
    valid           = 1'b0;
    case (state_q)
      S_INIT:     state_d = S_SETUP;
      S_SETUP:    state_d = S_WAIT_IN;
      S_WAIT_IN:  if (in_read_ready) state_d = S_POP;
      S_POP: begin
        in_read_valid = 1'b1;
        state_d       = S_ACC;
      end
      S_ACC:      state_d = S_CHECK;
      S_CHECK:    state_d = (cnt_q == CNT_LAST) ? S_WAIT_OUT : S_WAIT_IN;
      S_WAIT_OUT: if (out_write_ready) state_d = S_PUSH;
      S_PUSH: begin
        out_write_valid = 1'b1;
        state_d         = S_DONE;
      end
      S_DONE:     valid = 1'b1;
      default:    state_d = S_INIT;
    endcase
  end

  // The accumulator is presented continuously so it is stable through the push.
  assign out_in_data    = acc_q;
  assign in_in_data     = '0;
  assign in_write_valid = 1'b0;
  assign in_rst         = 1'b0;
  assign out_read_valid = 1'b0;
  assign out_rst        = 1'b0;
  assign unused_ok      = ^{out_out_data, out_read_ready};

endmodule

// File: tb/tb_channel_reduce_unit.sv
// Scoreboard bench for channel_reduce_unit with randomized channel handshakes and data.
module tb_channel_reduce_unit;

  localparam int W       = 32;
  localparam int C       = 4;
  localparam int SCHED_N = 512;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_out_data;
  logic         in_read_ready;
  logic         in_read_valid;
  logic [W-1:0] in_in_data;
  logic         in_write_valid;
  logic         in_rst;
  logic [W-1:0] out_in_data;
  logic         out_write_ready;
  logic         out_write_valid;
  logic         out_read_valid;
  logic         out_rst;
  logic [W-1:0] out_out_data;
  logic         out_read_ready;
  logic         valid;

  channel_reduce_unit #(.WIDTH(W), .COUNT(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_out_data(in_out_data), .in_read_ready(in_read_ready), .in_read_valid(in_read_valid),
    .in_in_data(in_in_data), .in_write_valid(in_write_valid), .in_rst(in_rst),
    .out_in_data(out_in_data), .out_write_ready(out_write_ready), .out_write_valid(out_write_valid),
    .out_read_valid(out_read_valid), .out_rst(out_rst),
    .out_out_data(out_out_data), .out_read_ready(out_read_ready), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    int           push_edge;
    int           valid_edge;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] in_words[$];
  bit           in_sched[SCHED_N];
  bit           out_sched[SCHED_N];
  logic [W-1:0] wv[C];
  int           sv[C];
  int           checks = 0;
  int           errors = 0;
  int           edge_cnt;
  int           pops, pushes;
  int           cur_valid_edge;
  bit           valid_seen, hold_data, noise;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: arithmetic sum of the words, wrapped or clamped to the data width.
  function automatic logic [W-1:0] model_sum();
    longint unsigned t = 0;
    for (int i = 0; i < C; i++) t += longint'(wv[i]);
`ifdef CHANNEL_REDUCE_SATURATE_EN
    if (t > 64'h0000_0000_FFFF_FFFF) return {W{1'b1}};
`endif
    return W'(t);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  // Channel models and monitor, all sampled on the falling edge.
  always @(negedge clk) begin
    int idx;
    exp_t e;
    if (rst_n) begin
      if (out_write_valid) begin
        pushes++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_push actual=%0h required=none", out_in_data);
        end else begin
          e = exp_q.pop_front();
          check("push_sum", out_in_data, e.sum);
          check("push_edge", edge_cnt, e.push_edge);
          cur_valid_edge = e.valid_edge;
        end
      end
      if (valid && !valid_seen) begin
        valid_seen = 1'b1;
        check("valid_edge", edge_cnt, cur_valid_edge);
      end else if (!valid && valid_seen) begin
        errors++;
        $display("FAIL valid_sticky actual=0 required=1");
      end
      if (in_read_valid) begin
        pops++;
        if (in_words.size() > 0) in_out_data = in_words.pop_front();
        hold_data = 1'b1;
      end else if (hold_data) begin
        hold_data = 1'b0;
      end else if (noise) begin
        in_out_data = $urandom;
      end
    end
    idx = edge_cnt + 1;
    in_read_ready   = (idx < SCHED_N) ? in_sched[idx] : 1'b1;
    out_write_ready = (idx < SCHED_N) ? out_sched[idx] : 1'b1;
    if (noise) begin
      out_out_data   = $urandom;
      out_read_ready = 1'($urandom_range(0, 1));
    end
  end

  // Ready schedules indexed by rising edge after reset release; a stall window starts
  // exactly at the edge where the kernel first checks ready for that word.
  task automatic build_sched(input int L, input bit nz, output int push_e, output int valid_e);
    int s_tot = 0;
    int ce, oce;
    for (int e = 0; e < SCHED_N; e++) begin
      in_sched[e]  = 1'b1;
      out_sched[e] = 1'b1;
    end
    if (nz) begin
      in_sched[1] = 1'($urandom_range(0, 1));
      in_sched[2] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < C; k++) begin
      ce = 3 + 4 * k + s_tot;
      for (int j = 0; j < sv[k]; j++) in_sched[ce + j] = 1'b0;
      if (nz) for (int j = 1; j <= 3; j++) in_sched[ce + sv[k] + j] = 1'($urandom_range(0, 1));
      s_tot += sv[k];
    end
    oce = 3 + 4 * C + s_tot;
    if (nz) for (int e = 1; e < oce; e++) out_sched[e] = 1'($urandom_range(0, 1));
    for (int j = 0; j < L; j++) out_sched[oce + j] = 1'b0;
    push_e  = oce + L;
    valid_e = push_e + 1;
  endtask

  task automatic start_txn(input int L, input bit nz, input bit expect_push);
    exp_t e;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {in_read_valid, out_write_valid, valid, out_in_data}, 64'd0);
    noise      = nz;
    pops       = 0;
    pushes     = 0;
    valid_seen = 1'b0;
    hold_data  = 1'b0;
    in_words.delete();
    for (int i = 0; i < C; i++) in_words.push_back(wv[i]);
    build_sched(L, nz, e.push_edge, e.valid_edge);
    e.sum = model_sum();
    cur_valid_edge = e.valid_edge;
    if (expect_push) exp_q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input int L, input bit nz);
    int n;
    start_txn(L, nz, 1'b1);
    n = 0;
    while (!valid_seen && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!valid_seen) begin
      errors++;
      $display("FAIL valid_timeout actual=0 required=1");
    end
    repeat (5) @(negedge clk);
    #1;
    check("pop_count", pops, C);
    check("push_count", pushes, 1);
    check("valid_held", valid, 1'b1);
    check("tied_outputs", {in_in_data, in_write_valid, in_rst, out_read_valid, out_rst}, 64'd0);
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    in_read_ready   = 1'b0;
    out_write_ready = 1'b0;
    in_out_data     = '0;
    out_out_data    = '0;
    out_read_ready  = 1'b0;
    noise           = 1'b0;
    repeat (2) @(negedge clk);

    wv = '{32'd1, 32'd2, 32'd3, 32'd4};
    sv = '{0, 0, 0, 0};
    run_txn(0, 1'b0);

    sv = '{0, 5, 0, 0};
    run_txn(0, 1'b0);

    wv = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    sv = '{0, 0, 0, 0};
    run_txn(0, 1'b0);

    wv = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_txn(10, 1'b0);

    // Abort after the second pop, while its strobe is still high.
    start_txn(0, 1'b0, 1'b0);
    n = 0;
    while (pops < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pops_before_abort", pops, 2);
    check("strobe_before_abort", in_read_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {in_read_valid, out_write_valid, valid, out_in_data}, 64'd0);
    @(negedge clk);
    check("abort_no_push", pushes, 0);

    wv = '{32'd5, 32'd5, 32'd5, 32'd5};
    run_txn(0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < C; i++) begin
        wv[i] = (t % 2 == 0) ? $urandom : 32'($urandom_range(0, 1000));
        sv[i] = $urandom_range(0, 4);
      end
      run_txn($urandom_range(0, 6), 1'b1);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
